disparity_stream_framer: RTL and testbench
==========================================

Name: disparity_stream_framer

Overview:
Transmit-side companion to the disparity filtering blocks: accepts an untagged pixel stream (disparity, confidence, gray) with a start-of-frame marker. Emits it with first_pixel_in_line, last_pixel_in_line and last_pixel_in_frame tags derived from column/row counters. Guarantees exactly one last_pixel_in_frame per frame and enforces a post-frame quiet gap so downstream 3-tap filters can flush. Sits between the block-matching output and the bilateral filter chain; there is no backpressure.

Parameters:
disp_bits, 5, width of disparity field
frame_width, 640, pixels per line (>= 2)
frame_height, 480, lines per frame (>= 1)
flush_cycles, 3, quiet cycles enforced after last_pixel_in_frame (>= 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
pix_valid_in  in  1  input pixel strobe
sof_in  in  1  marks pixel (0,0); qualified by pix_valid_in
disparity_in  in  disp_bits  disparity
confidence_in  in  8  confidence
gray_in  in  8  grayscale
disparity_out  out  disp_bits  registered disparity
confidence_out  out  8  registered confidence
gray_out  out  8  registered gray
first_pixel_in_line  out  1  tag, valid with out_valid
last_pixel_in_line  out  1  tag, valid with out_valid
last_pixel_in_frame  out  1  tag, valid with out_valid
out_valid  out  1  output pixel strobe, 1-cycle pulse per pixel
frame_done  out  1  pulse, coincides with last_pixel_in_frame output
frame_error  out  1  pulse: sof_in seen mid-frame
dropped_count  out  16  saturating count of discarded input pixels

Behaviour:
- Reset: clk, reset synchronous active-high. All outputs 0; state WAIT_SOF; col=0, row=0, flush counter 0. Reset mid-frame abandons the frame with no tags emitted; out_valid is 0 the cycle after reset asserts.
- Latency: 1 cycle from accepted input to out_valid. Data/tag registers load only on emit and hold otherwise. Tags are meaningful only when out_valid=1; they are zeroed on non-emit cycles.
- Input gaps (pix_valid_in=0) are allowed anywhere; counters hold.
- States:
  - WAIT_SOF:
    - pix_valid_in & sof_in: emit with first=1; col<=1; row<=0; -> ACTIVE.
    - pix_valid_in & !sof_in: drop; dropped_count++.
  - ACTIVE, pix_valid_in & !sof_in: emit.
    - first=(col==0); last_line=(col==frame_width-1); last_frame=last_line & (row==frame_height-1).
    - col wraps to 0 after frame_width-1, and row increments.
    - On last_frame: frame_done pulses with the output; flush counter<=flush_cycles; -> FLUSH.
  - ACTIVE, pix_valid_in & sof_in (premature SOF): frame_error pulses on the next cycle, alongside out_valid. The pixel is emitted as (0,0) of a new frame (first=1), col<=1, row<=0; stay ACTIVE. The truncated frame never receives last_pixel_in_frame.
  - FLUSH: counter decrements every cycle; all input pixels are dropped and counted, including any with sof_in. On the counter reaching 0 -> WAIT_SOF (ready the following cycle). Net effect: at least flush_cycles cycles with out_valid=0 follow every last_pixel_in_frame.
- frame_height=1: every last_pixel_in_line is also last_pixel_in_frame.
- dropped_count saturates at 0xFFFF; it is cleared only by reset.
- Width rules: col is clog2(frame_width) bits; row is clog2(frame_height) bits. The flush counter is clog2(flush_cycles+1) bits.

Decomposition:
- Shared package disparity_stream_pkg:
  - state enum typedef {WAIT_SOF, ACTIVE, FLUSH}.
  - Packed struct pixel_tags_t {first, last_line, last_frame}.
  - Packed struct pixel_data_t {disparity, confidence, gray}.
  - Default frame dimension constants.
- One natural sub-module: frame_position_counter. It holds col/row with wrap logic, has load-origin and advance inputs, and outputs the first/last_line/last_frame flags combinationally.

Test Plan:
- Use frame_width=4, frame_height=2, flush_cycles=3. Drive 8 back-to-back pixels, sof on the first. Required: out_valid for 8 cycles, starting 1 cycle late. first at outputs 0 and 4; last_line at outputs 3 and 7; last_frame and frame_done only at output 7; dropped_count=0.
- Same frame with pix_valid_in toggling every other cycle. Required: identical tag sequence; data order preserved.
- Send 3 pixels without sof, then a valid frame. Required: first 3 produce no output; dropped_count=3; the frame tags correctly.
- Send sof plus pixels back-to-back immediately after the last pixel of a frame. Required: the 3 pixels following last_frame are dropped (dropped_count +3), no out_valid during the gap, and the later sof starts a new frame.
- Send sof at input pixel 5 of a 4x2 frame. Required: frame_error pulses with that output; the output carries first=1; the following 7 pixels complete the new frame with last_frame on the 8th pixel of the new frame.
- Assert reset at pixel 6 for one cycle, then send a fresh frame. Required: outputs 0 during reset, no last_frame for the aborted frame, and the fresh frame tags correctly from (0,0).

Source files
------------

// File: rtl/disparity_stream_framer_pkg.sv
// Shared types and defaults for the disparity stream framer: FSM states,
// per-pixel tag/data bundles and a saturating counter helper.
package disparity_stream_pkg;

    localparam int default_disp_bits    = 5;
    localparam int default_frame_width  = 640;
    localparam int default_frame_height = 480;
    localparam int default_flush_cycles = 3;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACTIVE,
        FLUSH
    } state_t;

    typedef struct packed {
        logic first;
        logic last_line;
        logic last_frame;
    } pixel_tags_t;

    typedef struct packed {
        logic [default_disp_bits-1:0] disparity;
        logic [7:0]                   confidence;
        logic [7:0]                   gray;
    } pixel_data_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/disparity_stream_framer_if.sv
// Pixel stream bundle: untagged input side and tagged output side of the framer.
interface disparity_stream_framer_if #(
    parameter int disp_bits = 5
);
    logic                 pix_valid_in;
    logic                 sof_in;
    logic [disp_bits-1:0] disparity_in;
    logic [7:0]           confidence_in;
    logic [7:0]           gray_in;

    logic [disp_bits-1:0] disparity_out;
    logic [7:0]           confidence_out;
    logic [7:0]           gray_out;
    logic                 first_pixel_in_line;
    logic                 last_pixel_in_line;
    logic                 last_pixel_in_frame;
    logic                 out_valid;
    logic                 frame_done;
    logic                 frame_error;
    logic [15:0]          dropped_count;

    modport master (
        output pix_valid_in, sof_in, disparity_in, confidence_in, gray_in,
        input  disparity_out, confidence_out, gray_out,
               first_pixel_in_line, last_pixel_in_line, last_pixel_in_frame,
               out_valid, frame_done, frame_error, dropped_count
    );

    modport slave (
        input  pix_valid_in, sof_in, disparity_in, confidence_in, gray_in,
        output disparity_out, confidence_out, gray_out,
               first_pixel_in_line, last_pixel_in_line, last_pixel_in_frame,
               out_valid, frame_done, frame_error, dropped_count
    );
endinterface

// File: rtl/disparity_stream_framer_position.sv
// Column/row tracker for the framer; flags describe the pixel at the current
// position and are valid combinationally.
module frame_position_counter
    import disparity_stream_pkg::*;
#(
    parameter int frame_width  = default_frame_width,
    parameter int frame_height = default_frame_height
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_origin,
    input  logic        advance,
    output pixel_tags_t tags
);
    localparam int col_bits = $clog2(frame_width);
    // A single-line frame still needs a one-bit row register.
    localparam int row_bits = (frame_height > 1) ? $clog2(frame_height) : 1;

    localparam logic [col_bits-1:0] last_col = col_bits'(frame_width - 1);
    localparam logic [row_bits-1:0] last_row = row_bits'(frame_height - 1);

    logic [col_bits-1:0] col;
    logic [row_bits-1:0] row;

    assign tags.first      = (col == '0);
    assign tags.last_line  = (col == last_col);
    assign tags.last_frame = (col == last_col) && (row == last_row);

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (load_origin) begin
            // The origin pixel itself is being emitted, so the next one is column 1.
            col <= col_bits'(1);
            row <= '0;
        end else if (advance) begin
            // NOTE: non-blocking updates keep col and row consistent at the edge.
            if (col == last_col) begin
                col <= '0;
                row <= (row == last_row) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/disparity_stream_framer.sv
// Tags an untagged pixel stream with line/frame markers, guarantees one
// last_pixel_in_frame per frame and enforces a quiet gap after it.
module disparity_stream_framer
    import disparity_stream_pkg::*;
#(
    parameter int disp_bits    = default_disp_bits,
    parameter int frame_width  = default_frame_width,
    parameter int frame_height = default_frame_height,
    parameter int flush_cycles = default_flush_cycles
) (
    input logic clk,
    input logic reset,
    disparity_stream_framer_if.slave bus
);
    localparam int flush_bits = $clog2(flush_cycles + 1);
    localparam pixel_tags_t origin_tags = '{first: 1'b1, last_line: 1'b0, last_frame: 1'b0};

    state_t               state;
    logic [flush_bits-1:0] flush_cnt;
    pixel_tags_t          pos_tags;
    pixel_tags_t          tags_q;
    logic [disp_bits-1:0] disp_q;
    logic [7:0]           conf_q;
    logic [7:0]           gray_q;
    logic                 valid_q;
    logic                 done_q;
    logic                 error_q;
    logic [15:0]          drop_q;
    logic                 load_origin;
    logic                 advance;

    assign load_origin = bus.pix_valid_in && bus.sof_in && (state != FLUSH);
    assign advance     = bus.pix_valid_in && !bus.sof_in && (state == ACTIVE);

    frame_position_counter #(
        .frame_width (frame_width),
        .frame_height(frame_height)
    ) u_position (
        .clk        (clk),
        .reset      (reset),
        .load_origin(load_origin),
        .advance    (advance),
        .tags       (pos_tags)
    );

    always_ff @(posedge clk) begin
        // NOTE: synchronous active-high reset to match the surrounding filter chain.
        if (reset) begin
            state     <= WAIT_SOF;
            flush_cnt <= '0;
            tags_q    <= '0;
            disp_q    <= '0;
            conf_q    <= '0;
            gray_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            drop_q    <= '0;
        end else begin
            // NOTE: strobes and tags default low each cycle; data registers hold.
            valid_q <= 1'b0;
            tags_q  <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;

            if (load_origin || advance) begin
                valid_q <= 1'b1;
                disp_q  <= bus.disparity_in;
                conf_q  <= bus.confidence_in;
                gray_q  <= bus.gray_in;
            end

            case (state)
                WAIT_SOF: begin
                    if (bus.pix_valid_in) begin
                        if (bus.sof_in) begin
                            tags_q <= origin_tags;
                            state  <= ACTIVE;
                        end else begin
                            drop_q <= sat_inc16(drop_q);
                        end
                    end
                end
                ACTIVE: begin
                    if (bus.pix_valid_in) begin
                        if (bus.sof_in) begin
                            // Premature SOF restarts the frame; the truncated one gets no last tag.
                            tags_q  <= origin_tags;
                            error_q <= 1'b1;
                        end else begin
                            tags_q <= pos_tags;
                            if (pos_tags.last_frame) begin
                                done_q    <= 1'b1;
                                flush_cnt <= flush_bits'(flush_cycles);
                                state     <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - 1'b1;
                    if (flush_cnt <= flush_bits'(1)) state <= WAIT_SOF;
                    if (bus.pix_valid_in) drop_q <= sat_inc16(drop_q);
                end
                default: state <= WAIT_SOF;
            endcase
        end
    end

    assign bus.disparity_out       = disp_q;
    assign bus.confidence_out      = conf_q;
    assign bus.gray_out            = gray_q;
    assign bus.first_pixel_in_line = tags_q.first;
    assign bus.last_pixel_in_line  = tags_q.last_line;
    assign bus.last_pixel_in_frame = tags_q.last_frame;
    assign bus.out_valid           = valid_q;
    assign bus.frame_done          = done_q;
    assign bus.frame_error         = error_q;
    assign bus.dropped_count       = drop_q;

endmodule

// File: tb/tb_disparity_stream_framer.sv
// Self-checking bench for disparity_stream_framer: frame-index reference model
// compared every cycle, plus literal tag tables for the directed scenarios.
module tb_disparity_stream_framer;
    import disparity_stream_pkg::*;

    localparam int fw = 4;
    localparam int fh = 2;
    localparam int fc = 3;
    localparam int db = default_disp_bits;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    disparity_stream_framer_if #(.disp_bits(db)) bus ();

    disparity_stream_framer #(
        .disp_bits   (db),
        .frame_width (fw),
        .frame_height(fh),
        .flush_cycles(fc)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: position is the pixel index inside the open frame (-1 = none).
    int          pos = -1;
    int          quiet = 0;
    logic [15:0] m_drop = '0;
    pixel_data_t m_data = '0;
    logic        m_valid, m_first, m_ll, m_lf, m_fd, m_fe;
    bit          armed = 0;

    // Tag log of emitted pixels: {first, last_line, last_frame, frame_done, frame_error}.
    logic [4:0] log_q[$];

    task automatic model_step();
        bit emit = 0;
        m_valid = 0; m_first = 0; m_ll = 0; m_lf = 0; m_fd = 0; m_fe = 0;
        if (reset) begin
            pos = -1; quiet = 0; m_drop = '0; m_data = '0;
        end else if (quiet > 0) begin
            quiet--;
            if (bus.pix_valid_in && m_drop != 16'hFFFF) m_drop++;
        end else if (bus.pix_valid_in) begin
            if (bus.sof_in) begin
                m_fe = (pos >= 0);
                pos  = 0;
                emit = 1;
            end else if (pos < 0) begin
                if (m_drop != 16'hFFFF) m_drop++;
            end else begin
                emit = 1;
            end
        end
        if (emit) begin
            m_valid = 1;
            m_data  = '{bus.disparity_in, bus.confidence_in, bus.gray_in};
            m_first = (pos % fw == 0);
            m_ll    = (pos % fw == fw - 1);
            m_lf    = (pos == fw * fh - 1);
            if (m_lf) begin
                m_fd  = 1;
                quiet = fc;
                pos   = -1;
            end else begin
                pos++;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (armed) begin
            check("cycle",
                  {bus.out_valid, bus.first_pixel_in_line, bus.last_pixel_in_line,
                   bus.last_pixel_in_frame, bus.frame_done, bus.frame_error,
                   bus.dropped_count, bus.disparity_out, bus.confidence_out, bus.gray_out},
                  {m_valid, m_first, m_ll, m_lf, m_fd, m_fe, m_drop, m_data});
            if (bus.out_valid === 1'b1)
                log_q.push_back({bus.first_pixel_in_line, bus.last_pixel_in_line,
                                 bus.last_pixel_in_frame, bus.frame_done, bus.frame_error});
        end
        model_step();
        armed = 1;
    end

    task automatic step(input logic r, input logic v, input logic s);
        reset             = r;
        bus.pix_valid_in  = v;
        bus.sof_in        = s;
        bus.disparity_in  = db'($urandom);
        bus.confidence_in = 8'($urandom);
        bus.gray_in       = 8'($urandom);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, i == 0);
            if (gaps) step(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Hand-computed tag sequence of one clean 4x2 frame.
    logic [4:0] frame_tags[8] = '{5'b10000, 5'b00000, 5'b00000, 5'b01000,
                                  5'b10000, 5'b00000, 5'b00000, 5'b01110};
    // Five pixels, premature SOF (first + frame_error), then the rest of the new frame.
    logic [4:0] restart_tags[13] = '{5'b10000, 5'b00000, 5'b00000, 5'b01000, 5'b10000,
                                     5'b10001, 5'b00000, 5'b00000, 5'b01000,
                                     5'b10000, 5'b00000, 5'b00000, 5'b01110};

    task automatic check_frame_at(input string name, input int base);
        for (int i = 0; i < 8; i++)
            if (base + i < log_q.size()) check(name, log_q[base + i], frame_tags[i]);
    endtask

    initial begin
        bus.pix_valid_in = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(2);
        check("reset_drop", bus.dropped_count, 64'd0);
        check("reset_valid", bus.out_valid, 64'd0);

        // Back-to-back frame.
        log_q.delete();
        send_frame(8, 1'b0);
        idle(5);
        check("b2b_count", log_q.size(), 64'd8);
        check_frame_at("b2b_tags", 0);
        check("b2b_drop", bus.dropped_count, 64'd0);

        // Same frame with gaps on every other cycle.
        log_q.delete();
        send_frame(8, 1'b1);
        idle(5);
        check("gap_count", log_q.size(), 64'd8);
        check_frame_at("gap_tags", 0);

        // Pixels before any SOF are dropped.
        log_q.delete();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        send_frame(8, 1'b0);
        idle(5);
        check("nosof_drop", bus.dropped_count, 64'd3);
        check("nosof_count", log_q.size(), 64'd8);
        check_frame_at("nosof_tags", 0);

        // Traffic right after last_frame falls into the flush gap.
        log_q.delete();
        send_frame(8, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        send_frame(8, 1'b0);
        idle(5);
        check("flush_drop", bus.dropped_count, 64'd6);
        check("flush_count", log_q.size(), 64'd16);
        check_frame_at("flush_tags", 8);

        // Premature SOF at input pixel 5.
        log_q.delete();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, i == 0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
        idle(5);
        check("restart_count", log_q.size(), 64'd13);
        for (int i = 0; i < 13; i++)
            if (i < log_q.size()) check("restart_tags", log_q[i], restart_tags[i]);

        // Reset mid-frame, then a fresh frame.
        log_q.delete();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, i == 0);
        step(1'b1, 1'b1, 1'b0);
        check("midreset_valid", bus.out_valid, 64'd0);
        check("midreset_drop", bus.dropped_count, 64'd0);
        send_frame(8, 1'b0);
        idle(5);
        check("midreset_count", log_q.size(), 64'd14);
        for (int i = 0; i < 6; i++)
            if (i < log_q.size()) check("midreset_abort", log_q[i][2], 64'd0);
        check_frame_at("midreset_tags", 6);

        // Randomized traffic with occasional SOF and reset.
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 11) == 0);
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
